// File: rtl/mem_access_unit.sv
// mem_access_unit: sub-word load/store sequencer in front of a word-wide memory.
// Loads return sign/zero-extended bytes and halfwords. Byte and halfword stores
// are performed as read-modify-write so the memory only ever sees full words.
// Optional feature: define MEM_ACCESS_MISALIGN_TRAP_EN to flag misaligned
// halfword/word accesses with err instead of silently aligning them.
module mem_access_unit #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req,
  input  logic [3:0]            op,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_a,
  output logic [DATA_WIDTH-1:0] mem_wd,
  input  logic [DATA_WIDTH-1:0] mem_rd
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

  state_t                state;
  logic [3:0]            op_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;

  logic                  bad_req;
  logic [DATA_WIDTH-1:0] load_val;
  logic [DATA_WIDTH-1:0] merged;
  logic [DATA_WIDTH-1:0] byte_shift;
  logic [7:0]            rd_byte;
  logic [15:0]           rd_half;

  assign busy   = (state != IDLE);
  assign done   = (state == DONE);
  assign mem_we = (state == WRITE);
  assign mem_a  = {addr_q[ADDR_WIDTH-1:2], 2'b00};

  // Decide at request time whether the access completes immediately with an error
  always_comb begin
    bad_req = (op[1:0] == 2'b11);
`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
    if ((op[1:0] == 2'b01) && addr[0])
      bad_req = 1'b1;
    if ((op[1:0] == 2'b10) && (addr[1:0] != 2'b00))
      bad_req = 1'b1;
`endif
  end

  // Extract the addressed lane from the memory word and extend it for loads
  always_comb begin
    byte_shift = mem_rd >> {addr_q[1:0], 3'b000};
    rd_byte    = byte_shift[7:0];
    rd_half    = addr_q[1] ? mem_rd[31:16] : mem_rd[15:0];
    case (op_q[1:0])
      2'b00:   load_val = op_q[2] ? {24'b0, rd_byte} : {{24{rd_byte[7]}}, rd_byte};
      2'b01:   load_val = op_q[2] ? {16'b0, rd_half} : {{16{rd_half[15]}}, rd_half};
      default: load_val = mem_rd;
    endcase
  end

  // Build the write-back word for sub-word stores by replacing one lane of the read word
  always_comb begin
    merged = mem_rd;
    if (op_q[1:0] == 2'b00) begin
      merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
    end else if (addr_q[1]) begin
      merged[31:16] = wdata_q[15:0];
    end else begin
      merged[15:0] = wdata_q[15:0];
    end
  end

  // Sequencer: latch the request, optionally read, optionally write, then pulse done
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      op_q    <= 4'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata   <= '0;
      err     <= 1'b0;
      mem_wd  <= '0;
    end else begin
      case (state)
        IDLE: begin
          err <= 1'b0;
          if (req) begin
            op_q    <= op;
            addr_q  <= addr;
            wdata_q <= wdata;
            if (bad_req) begin
              err   <= 1'b1;
              state <= DONE;
            end else if (op[3] && (op[1:0] == 2'b10)) begin
              mem_wd <= wdata;
              state  <= WRITE;
            end else begin
              state <= READ;
            end
          end
        end
        READ: begin
          if (op_q[3]) begin
            mem_wd <= merged;
            state  <= WRITE;
          end else begin
            rdata <= load_val;
            state <= DONE;
          end
        end
        WRITE: begin
          state <= DONE;
        end
        DONE: begin
          err   <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed bench for mem_access_unit with a small word memory model.
module tb_mem_access_unit;

  localparam logic [3:0] OP_LB  = 4'b0000;
  localparam logic [3:0] OP_LH  = 4'b0001;
  localparam logic [3:0] OP_LW  = 4'b0010;
  localparam logic [3:0] OP_LBU = 4'b0100;
  localparam logic [3:0] OP_LHU = 4'b0101;
  localparam logic [3:0] OP_SB  = 4'b1000;
  localparam logic [3:0] OP_SH  = 4'b1001;
  localparam logic [3:0] OP_SW  = 4'b1010;
  localparam logic [3:0] OP_BAD = 4'b0011;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req = 1'b0;
  logic [3:0]  op = 4'b0;
  logic [31:0] addr = 32'b0;
  logic [31:0] wdata = 32'b0;
  logic        busy, done, err, mem_we;
  logic [31:0] rdata, mem_a, mem_wd, mem_rd;

  logic [31:0] mem [0:15];

  int checks = 0;
  int passes = 0;
  int done_count = 0;
  int we_count = 0;
  logic [31:0] last_we_addr = 32'b0;

  mem_access_unit #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .req    (req),
    .op     (op),
    .addr   (addr),
    .wdata  (wdata),
    .busy   (busy),
    .done   (done),
    .err    (err),
    .rdata  (rdata),
    .mem_we (mem_we),
    .mem_a  (mem_a),
    .mem_wd (mem_wd),
    .mem_rd (mem_rd)
  );

  always #5 clk = ~clk;

  // Word memory: combinational read, write on the rising edge while WE is high
  assign mem_rd = mem[mem_a[5:2]];
  always @(posedge clk) begin
    if (mem_we) mem[mem_a[5:2]] <= mem_wd;
  end

  // Count done pulses and write pulses as they end at each rising edge
  always @(posedge clk) begin
    if (done) done_count <= done_count + 1;
    if (mem_we) begin
      we_count     <= we_count + 1;
      last_we_addr <= mem_a;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected)
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, observed, expected);
    else
      passes++;
  endtask

  // Present one request; lat is the cycle offset of done relative to the accepting edge
  task automatic applyStimulus(input logic [3:0] o, input logic [31:0] a, input logic [31:0] d,
                               input bit hold, output int lat, output logic err_seen);
    @(negedge clk);
    req = 1'b1; op = o; addr = a; wdata = d;
    @(negedge clk);
    if (!hold) req = 1'b0;
    lat = -1;
    err_seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (done) begin
        lat = i;
        err_seen = err;
        break;
      end
      @(negedge clk);
    end
    req = 1'b0;
  endtask

  int lat;
  logic e;
  int d0, w0;

  initial begin
    $display("[TB] start");
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("rst_busy", {31'b0, busy}, 32'd0);
    checkOutput("rst_done", {31'b0, done}, 32'd0);
    checkOutput("rst_err", {31'b0, err}, 32'd0);
    checkOutput("rst_we", {31'b0, mem_we}, 32'd0);
    checkOutput("rst_rdata", rdata, 32'h0);
    checkOutput("rst_mem_a", mem_a, 32'h0);
    checkOutput("rst_mem_wd", mem_wd, 32'h0);
    rst_n = 1'b1;

    w0 = we_count;
    applyStimulus(OP_SW, 32'h10, 32'h8899AABB, 1'b0, lat, e);
    checkOutput("sw_lat", lat, 32'd1);
    checkOutput("sw_err", {31'b0, e}, 32'd0);
    @(negedge clk);
    checkOutput("sw_we_pulses", we_count - w0, 32'd1);
    checkOutput("sw_we_addr", last_we_addr, 32'h10);
    checkOutput("sw_mem", mem[4], 32'h8899AABB);

    applyStimulus(OP_LB, 32'h11, 32'h0, 1'b0, lat, e);
    checkOutput("lb_lat", lat, 32'd1);
    checkOutput("lb_data", rdata, 32'hFFFFFFAA);
    applyStimulus(OP_LBU, 32'h11, 32'h0, 1'b0, lat, e);
    checkOutput("lbu_data", rdata, 32'h000000AA);
    applyStimulus(OP_LH, 32'h12, 32'h0, 1'b0, lat, e);
    checkOutput("lh_data", rdata, 32'hFFFF8899);
    applyStimulus(OP_LHU, 32'h12, 32'h0, 1'b0, lat, e);
    checkOutput("lhu_data", rdata, 32'h00008899);

    applyStimulus(OP_SB, 32'h13, 32'h00000012, 1'b0, lat, e);
    checkOutput("sb_lat", lat, 32'd2);
    checkOutput("sb_mem", mem[4], 32'h1299AABB);
    applyStimulus(OP_SH, 32'h10, 32'h00003456, 1'b0, lat, e);
    checkOutput("sh_lat", lat, 32'd2);
    applyStimulus(OP_LW, 32'h10, 32'h0, 1'b0, lat, e);
    checkOutput("lw_lat", lat, 32'd1);
    checkOutput("lw_data", rdata, 32'h12993456);

    w0 = we_count;
    applyStimulus(OP_LW, 32'h12, 32'h0, 1'b0, lat, e);
`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
    checkOutput("mis_lat", lat, 32'd0);
    checkOutput("mis_err", {31'b0, e}, 32'd1);
`else
    checkOutput("mis_lat", lat, 32'd1);
    checkOutput("mis_err", {31'b0, e}, 32'd0);
`endif
    @(negedge clk);
    checkOutput("mis_rdata", rdata, 32'h12993456);
    checkOutput("mis_no_we", we_count - w0, 32'd0);

    w0 = we_count;
    applyStimulus(OP_BAD, 32'h10, 32'hFFFFFFFF, 1'b0, lat, e);
    checkOutput("bad_lat", lat, 32'd0);
    checkOutput("bad_err", {31'b0, e}, 32'd1);
    @(negedge clk);
    checkOutput("bad_err_clr", {31'b0, err}, 32'd0);
    checkOutput("bad_rdata", rdata, 32'h12993456);
    checkOutput("bad_no_we", we_count - w0, 32'd0);
    checkOutput("bad_mem", mem[4], 32'h12993456);

    d0 = done_count;
    applyStimulus(OP_LB, 32'h10, 32'h0, 1'b1, lat, e);
    checkOutput("hold_lb_data", rdata, 32'h00000056);
    repeat (4) @(negedge clk);
    checkOutput("hold_lb_dones", done_count - d0, 32'd1);
    d0 = done_count;
    w0 = we_count;
    applyStimulus(OP_SB, 32'h10, 32'h00000077, 1'b1, lat, e);
    checkOutput("hold_sb_lat", lat, 32'd2);
    repeat (4) @(negedge clk);
    checkOutput("hold_sb_dones", done_count - d0, 32'd1);
    checkOutput("hold_sb_wes", we_count - w0, 32'd1);
    checkOutput("hold_sb_mem", mem[4], 32'h12993477);

    d0 = done_count;
    w0 = we_count;
    @(negedge clk);
    req = 1'b1; op = OP_SB; addr = 32'h13; wdata = 32'h000000AB;
    @(negedge clk);
    req = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    checkOutput("rrd_busy", {31'b0, busy}, 32'd0);
    repeat (3) @(negedge clk);
    checkOutput("rrd_mem", mem[4], 32'h12993477);
    checkOutput("rrd_dones", done_count - d0, 32'd0);
    checkOutput("rrd_wes", we_count - w0, 32'd0);

    d0 = done_count;
    @(negedge clk);
    req = 1'b1; op = OP_SB; addr = 32'h13; wdata = 32'h000000CD;
    @(negedge clk);
    req = 1'b0;
    @(negedge clk);
    checkOutput("rwr_we_high", {31'b0, mem_we}, 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    checkOutput("rwr_busy", {31'b0, busy}, 32'd0);
    checkOutput("rwr_we_low", {31'b0, mem_we}, 32'd0);
    checkOutput("rwr_rdata", rdata, 32'h0);
    repeat (3) @(negedge clk);
    checkOutput("rwr_mem", mem[4], 32'hCD993477);
    checkOutput("rwr_dones", done_count - d0, 32'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Sub-word load/store sequencer placed directly in front of the word-wide `memory` block of the multi-cycle MIPS datapath. It accepts one load or store request at a time and drives the memory's `WE`/`A`/`WD` ports. For loads, it captures `RD` and returns a sign- or zero-extended result. Byte and halfword stores are done as read-modify-write, so the memory itself stays word-only.

## Interface
Parameters:
- `ADDR_WIDTH`, 32, byte-address width; `mem_a` width equals it
- `DATA_WIDTH`, 32, fixed at 32; any other value is unsupported

Ports:
- `clk` in 1: single clock, rising edge
- `rst_n` in 1: reset; one clock; reset is synchronous and active-low
- `req` in 1: request strobe, sampled only while `busy`=0
- `op` in 4: `op[3]`=store, `op[2]`=unsigned load, `op[1:0]` size (00 byte, 01 half, 10 word, 11 illegal)
- `addr` in ADDR_WIDTH: byte address
- `wdata` in 32: store data, right-justified
- `busy` out 1: 1 in every state except IDLE
- `done` out 1: one-cycle completion pulse
- `err` out 1: valid with `done`; illegal size or trapped misalignment
- `rdata` out 32: extended load result, held until the next load completes
- `mem_we` out 1: to memory `WE`
- `mem_a` out ADDR_WIDTH: to memory `A`, always `{addr[AW-1:2],2'b00}`
- `mem_wd` out 32: to memory `WD`
- `mem_rd` in 32: from memory `RD`; combinational read of `mem_a`

## Operation
- **States:** IDLE, READ, WRITE, DONE. The outputs are Moore decodes of state and registers: `mem_we`=1 only in WRITE, `busy`=0 only in IDLE, `done`=1 only in DONE.
- **IDLE, with `req`=1:** latch `op`, `addr` and `wdata`, then take the first matching case:
  - size 11 → DONE with `err`=1.
  - misaligned under trap (see Configuration) → DONE with `err`=1.
  - SW → WRITE.
  - any other access → READ.
- **READ:** `mem_a` is held at the word address. At the next edge `mem_rd` is captured into the internal word register. Then loads go to DONE and sub-word stores go to WRITE.
- **WRITE:** `mem_wd` carries the full word for SW. For SB/SH it carries the captured word with the selected lane replaced by `wdata[7:0]` or `wdata[15:0]`. The state then goes to DONE.
- **DONE:** go to IDLE unconditionally. A `req` asserted while in DONE is ignored.
- **Byte lanes (little-endian):**
  - byte n occupies bits `[8n+7:8n]`, with n=`addr[1:0]`.
  - the halfword is bits `[15:0]` if `addr[1]`=0, else `[31:16]`.
- **Load extension:** sign-extend when `op[2]`=0, zero-extend when `op[2]`=1. `op[2]` is ignored for word accesses and for stores.
- **`rdata` and `err`:**
  - `rdata` updates only on a successful load.
  - when `err`=1, `rdata` is unchanged and no memory write occurs.
  - `err` is held at 0 whenever `done`=0.
- **Reset values:** state=IDLE, `busy`=0, `done`=0, `err`=0, `rdata`=0, `mem_we`=0, `mem_a`=0, `mem_wd`=0.
- **Reset mid-operation:** if `rst_n` is low at an edge, the unit returns to IDLE with all outputs at reset values after that edge.
  - If reset is sampled at the edge that ends WRITE, the memory still writes at that same edge, because `mem_we` was already high.
  - If reset is sampled in READ, the read-modify-write is abandoned and memory is unchanged.

## Timing
Request sampled at edge N (cycle k means the cycle starting at edge k):
- **LB/LH/LW:** READ in cycle N; `done`=1 and `rdata` valid in cycle N+1.
- **SW:** WRITE in cycle N; the memory writes at edge N+1; `done` in cycle N+1.
- **SB/SH:** READ in cycle N, WRITE in cycle N+1; the memory writes at edge N+2; `done` in cycle N+2.
- **Error:** `done`=1 and `err`=1 in cycle N; no `mem_we` pulse.
- **Throughput:** the earliest next request is accepted at the edge ending DONE plus one, i.e. at the first edge while IDLE.
- **`mem_wd`:** stable for the whole WRITE cycle; `mem_a` is stable from cycle N until the end of the operation.

## Configuration
Macro `MEM_ACCESS_MISALIGN_TRAP_EN`:
- **Defined:**
  - a halfword access with `addr[0]`=1 is flagged `err`=1.
  - a word access with `addr[1:0]`≠00 is flagged `err`=1.
  - a flagged access causes no memory access, no write, and `rdata` unchanged.
- **Undefined:** the offending low address bits are forced to zero and the access completes normally with `err`=0:
  - halfword uses `addr[1]` only.
  - word ignores `addr[1:0]`.

## Test plan
- **Reset:** hold `rst_n`=0 for 2 cycles → all outputs 0 and `busy`=0. Then SW `addr`=0x10, `wdata`=0x8899AABB → one `mem_we` pulse with `mem_a`=0x10; `done` in cycle N+1.
- **Load extension:** preload word 0x10=0x8899AABB.
  - LB at 0x11 → `rdata`=0xFFFFFFAA.
  - LBU at 0x11 → `rdata`=0x000000AA.
  - LH at 0x12 → `rdata`=0xFFFF8899.
  - LHU at 0x12 → `rdata`=0x00008899.
- **Sub-word stores:** SB at 0x13 with `wdata`=0x12, then SH at 0x10 with `wdata`=0x3456, then LW at 0x10 → 0x1299 3456, i.e. 0x12993456. `done` arrives 2 cycles after each store request.
- **Misalignment:** LW at 0x12.
  - Macro defined → `done`=1 and `err`=1 in cycle N, no `mem_we`, `rdata` unchanged.
  - Macro undefined → returns word 0x10; `err`=0.
- **Illegal size and ignored requests:** `op[1:0]`=11 → `err`=1. A `req` held high during READ/WRITE/DONE starts no second operation; exactly one `done` per accepted request.
- **Reset mid-operation:**
  - assert `rst_n`=0 during READ of SB 0x13 → word 0x10 unchanged, unit in IDLE, `done` never pulses.
  - assert `rst_n`=0 at the edge ending WRITE of SB 0x13 → memory is written at that edge, `done` never pulses.
